// File: rtl/subleq_pkg.sv
// Shared types and helpers for the SUBLEQ execution core.
package subleq_pkg;

  // Widest DATA_W accepted by is_leq_zero.
  localparam int unsigned MAX_DATA_W = 64;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_WAIT_A,
    ST_FETCH_B,
    ST_WAIT_B,
    ST_READ_A,
    ST_WAIT_RA,
    ST_READ_B,
    ST_WAIT_RB,
    ST_WRITE,
    ST_FETCH_C,
    ST_WAIT_C,
    ST_HALT
  } subleq_state_e;

  // True when the low `width` bits of value, read as two's complement, are <= 0.
  function automatic logic is_leq_zero(input logic [MAX_DATA_W-1:0] value,
                                       input int unsigned            width);
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] shifted;
    mask    = ~({MAX_DATA_W{1'b1}} << width);
    shifted = value >> (width - 1);
    return shifted[0] | ((value & mask) == '0);
  endfunction

endpackage

// File: rtl/subleq_core.sv
// SUBLEQ core: mem[B] <- mem[B] - mem[A]; branch to C when the result is <= 0.
// One request/grant/rvalid memory port, at most one request outstanding.
//
// state      | meaning
// IDLE       | between instructions, waits for run
// FETCH_A    | read request for A at pc, waits for gnt
// WAIT_A     | waits for rvalid carrying A
// FETCH_B    | read request for B at pc+1
// WAIT_B     | waits for rvalid carrying B
// READ_A     | read request for mem[A]
// WAIT_RA    | waits for rvalid carrying mem[A]
// READ_B     | read request for mem[B]
// WAIT_RB    | waits for rvalid carrying mem[B], forms the difference
// WRITE      | write request of the difference to B
// FETCH_C    | read request for C at pc+2 (branch taken only)
// WAIT_C     | waits for rvalid carrying C, retires
// HALT       | self-loop detected, left only by reset
module subleq_core
  import subleq_pkg::*;
#(
  parameter int unsigned       DATA_W            = 32,
  parameter int unsigned       ADDR_W            = 16,
  parameter logic [ADDR_W-1:0] RESET_PC          = '0,
  parameter bit                HALT_ON_SELF_LOOP = 1'b1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       retired
);

  subleq_state_e     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic [31:0]       retired_q, retired_d;

  logic [DATA_W-1:0] diff;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    retired_d   = retired_q;
    diff        = mem_rdata - a_data_q;
    rd_addr     = mem_rdata[ADDR_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (run && !halted_q) begin
          state_d    = ST_FETCH_A;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end
      end
      ST_FETCH_A: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT_A;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT_A: begin
        if (mem_rvalid) begin
          a_addr_d   = rd_addr;
          state_d    = ST_FETCH_B;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q + ADDR_W'(1);
        end
      end
      ST_FETCH_B: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT_B;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT_B: begin
        if (mem_rvalid) begin
          b_addr_d   = rd_addr;
          state_d    = ST_READ_A;
          mem_req_d  = 1'b1;
          mem_addr_d = a_addr_q;
        end
      end
      ST_READ_A: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT_RA;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT_RA: begin
        if (mem_rvalid) begin
          a_data_d   = mem_rdata;
          state_d    = ST_READ_B;
          mem_req_d  = 1'b1;
          mem_addr_d = b_addr_q;
        end
      end
      ST_READ_B: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT_RB;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT_RB: begin
        if (mem_rvalid) begin
          b_data_d    = diff;
          state_d     = ST_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = b_addr_q;
          mem_wdata_d = diff;
        end
      end
      ST_WRITE: begin
        if (mem_gnt) begin
          mem_we_d = 1'b0;
          if (is_leq_zero(MAX_DATA_W'(b_data_q), DATA_W)) begin
            state_d    = ST_FETCH_C;
            mem_addr_d = pc_q + ADDR_W'(2);
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            pc_d      = pc_q + ADDR_W'(3);
            retired_d = retired_q + 32'd1;
          end
        end
      end
      ST_FETCH_C: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT_C;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT_C: begin
        if (mem_rvalid) begin
          pc_d      = rd_addr;
          retired_d = retired_q + 32'd1;
          // A taken branch onto its own pc can never make progress.
          if (HALT_ON_SELF_LOOP && (rd_addr == pc_q)) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_HALT);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_subleq_core.sv
// Directed bench: a 32-bit core on a delay-programmable memory, and an 8-bit core
// without self-loop halt on a zero-wait memory.
module tb_subleq_core;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst  = 1'b1;
  logic run  = 1'b0;
  logic run8 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata, retired;
  logic        busy, halted;

  logic [31:0] mem [0:255];
  int          gwait   = 0;
  int          rv_cnt  = 0;
  logic        rv_pend = 1'b0;
  logic [31:0] rv_data = '0;
  int          max_gd  = 0;
  int          min_rd  = 0;
  int          max_rd  = 0;
  int          n_rd2   = 0;
  int          n_writes = 0;

  subleq_core #(.DATA_W(32), .ADDR_W(16), .RESET_PC(16'd0), .HALT_ON_SELF_LOOP(1'b1)) dut (
    .clock(clock), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pc(pc), .busy(busy), .halted(halted), .retired(retired)
  );

  assign mem_gnt    = mem_req && (gwait == 0);
  assign mem_rvalid = rv_pend && (rv_cnt == 0);
  assign mem_rdata  = rv_data;

  always @(posedge clock) begin
    if (mem_rvalid) rv_pend <= 1'b0;
    else if (rv_pend) rv_cnt <= rv_cnt - 1;
    if (mem_gnt) begin
      if (mem_we) begin
        mem[mem_addr[7:0]] = mem_wdata;
        n_writes = n_writes + 1;
      end else begin
        rv_pend <= 1'b1;
        rv_cnt  <= int'($urandom_range(max_rd, min_rd));
        rv_data <= mem[mem_addr[7:0]];
        if (mem_addr == 16'd2) n_rd2 = n_rd2 + 1;
      end
      gwait <= int'($urandom_range(max_gd, 0));
    end else if (mem_req && gwait > 0) begin
      gwait <= gwait - 1;
    end
  end

  logic       m8_req, m8_we, m8_gnt;
  logic       m8_rvalid = 1'b0;
  logic [7:0] m8_addr, m8_wdata, pc8;
  logic [7:0] m8_rdata = '0;
  logic       busy8, halted8;
  logic [31:0] retired8;
  logic [7:0] mem8 [0:255];

  subleq_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'd0), .HALT_ON_SELF_LOOP(1'b0)) dut8 (
    .clock(clock), .rst(rst), .run(run8),
    .mem_req(m8_req), .mem_we(m8_we), .mem_addr(m8_addr), .mem_wdata(m8_wdata),
    .mem_gnt(m8_gnt), .mem_rvalid(m8_rvalid), .mem_rdata(m8_rdata),
    .pc(pc8), .busy(busy8), .halted(halted8), .retired(retired8)
  );

  assign m8_gnt = m8_req;

  always @(posedge clock) begin
    m8_rvalid <= m8_req && !m8_we;
    if (m8_req && !m8_we) m8_rdata <= mem8[m8_addr];
    if (m8_req && m8_we) mem8[m8_addr] = m8_wdata;
  end

  // Leaves rst asserted with both memories cleared; callers load and release.
  task automatic hold_reset();
    @(negedge clock);
    rst = 1'b1; run = 1'b0; run8 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 256; i++) begin
      mem[i]  = '0;
      mem8[i] = '0;
    end
    n_rd2 = 0;
    n_writes = 0;
  endtask

  task automatic test_reset();
    hold_reset();
    rst = 1'b0;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, pc, busy, halted, retired} !== '0) begin
      n_fail++;
      $display("FAIL reset32: req=%b we=%b addr=%0d wdata=%0d pc=%0d busy=%b halted=%b retired=%0d, all must be 0",
               mem_req, mem_we, mem_addr, mem_wdata, pc, busy, halted, retired);
    end
    n_checks++;
    if ({m8_req, m8_we, m8_addr, m8_wdata, pc8, busy8, halted8, retired8} !== '0) begin
      n_fail++;
      $display("FAIL reset8: req=%b we=%b addr=%0d pc=%0d busy=%b retired=%0d, all must be 0",
               m8_req, m8_we, m8_addr, pc8, busy8, retired8);
    end
  endtask

  task automatic test_taken();
    int bc = 0;
    hold_reset();
    max_gd = 0; min_rd = 0; max_rd = 0;
    mem[0] = 3; mem[1] = 4; mem[2] = 6; mem[3] = 5; mem[4] = 5;
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      run = 1'b0;
      if (busy) bc++;
    end
    n_checks++;
    if (mem[4] !== 32'd0) begin n_fail++; $display("FAIL taken_mem4: got %0d expected 0", mem[4]); end
    n_checks++;
    if (pc !== 16'd6) begin n_fail++; $display("FAIL taken_pc: got %0d expected 6", pc); end
    n_checks++;
    if (retired !== 32'd1) begin n_fail++; $display("FAIL taken_retired: got %0d expected 1", retired); end
    n_checks++;
    if (bc != 11) begin n_fail++; $display("FAIL taken_busy_cycles: got %0d expected 11", bc); end
    n_checks++;
    if (n_rd2 != 1) begin n_fail++; $display("FAIL taken_c_fetch: reads at 2 got %0d expected 1", n_rd2); end
  endtask

  task automatic test_not_taken();
    int bc = 0;
    hold_reset();
    max_gd = 0; min_rd = 0; max_rd = 0;
    mem[0] = 3; mem[1] = 4; mem[2] = 9; mem[3] = 2; mem[4] = 7;
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      run = 1'b0;
      if (busy) bc++;
    end
    n_checks++;
    if (mem[4] !== 32'd5) begin n_fail++; $display("FAIL nt_mem4: got %0d expected 5", mem[4]); end
    n_checks++;
    if (pc !== 16'd3) begin n_fail++; $display("FAIL nt_pc: got %0d expected 3", pc); end
    n_checks++;
    if (bc != 9) begin n_fail++; $display("FAIL nt_busy_cycles: got %0d expected 9", bc); end
    n_checks++;
    if (n_rd2 != 0) begin n_fail++; $display("FAIL nt_no_c_fetch: reads at 2 got %0d expected 0", n_rd2); end
    n_checks++;
    if (retired !== 32'd1) begin n_fail++; $display("FAIL nt_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_width8();
    bit first_seen = 1'b0;
    hold_reset();
    mem8[0] = 8'd10; mem8[1] = 8'd11; mem8[2] = 8'd20;
    mem8[3] = 8'd12; mem8[4] = 8'd13; mem8[5] = 8'd20;
    mem8[10] = 8'h01; mem8[11] = 8'h80;
    mem8[12] = 8'h01; mem8[13] = 8'h81;
    rst = 1'b0;
    run8 = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (retired8 == 32'd1 && !first_seen) begin
        first_seen = 1'b1;
        n_checks++;
        if (mem8[11] !== 8'h7f) begin n_fail++; $display("FAIL w8_wrap_pos: got %h expected 7f", mem8[11]); end
        n_checks++;
        if (pc8 !== 8'd3) begin n_fail++; $display("FAIL w8_not_taken_pc: got %0d expected 3", pc8); end
      end
      if (retired8 == 32'd2) begin
        run8 = 1'b0;
        break;
      end
    end
    run8 = 1'b0;
    n_checks++;
    if (retired8 !== 32'd2) begin n_fail++; $display("FAIL w8_retired: got %0d expected 2", retired8); end
    n_checks++;
    if (mem8[13] !== 8'h80) begin n_fail++; $display("FAIL w8_wrap_neg: got %h expected 80", mem8[13]); end
    n_checks++;
    if (pc8 !== 8'd20) begin n_fail++; $display("FAIL w8_taken_pc: got %0d expected 20", pc8); end
  endtask

  task automatic test_self_loop_halt();
    int reqs = 0;
    hold_reset();
    max_gd = 0; min_rd = 0; max_rd = 0;
    mem[0] = 30; mem[1] = 31; mem[2] = 12;
    mem[12] = 30; mem[13] = 30; mem[14] = 12;
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (halted) break;
    end
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b expected 1", halted); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy: got %b expected 0", busy); end
    n_checks++;
    if (pc !== 16'd12) begin n_fail++; $display("FAIL halt_pc: got %0d expected 12", pc); end
    n_checks++;
    if (retired !== 32'd2) begin n_fail++; $display("FAIL halt_retired: got %0d expected 2", retired); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_req) reqs++;
    end
    run = 1'b0;
    n_checks++;
    if (reqs != 0) begin n_fail++; $display("FAIL halt_no_req: got %0d requests expected 0", reqs); end
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b expected 1", halted); end
  endtask

  task automatic test_self_loop_no_halt();
    hold_reset();
    mem8[0] = 8'd30; mem8[1] = 8'd31; mem8[2] = 8'd12;
    mem8[12] = 8'd30; mem8[13] = 8'd30; mem8[14] = 8'd12;
    rst = 1'b0;
    run8 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (retired8 == 32'd6) break;
    end
    run8 = 1'b0;
    n_checks++;
    if (retired8 !== 32'd6) begin n_fail++; $display("FAIL nohalt_retired: got %0d expected 6", retired8); end
    n_checks++;
    if (halted8 !== 1'b0) begin n_fail++; $display("FAIL nohalt_flag: got %b expected 0", halted8); end
    n_checks++;
    if (pc8 !== 8'd12) begin n_fail++; $display("FAIL nohalt_pc: got %0d expected 12", pc8); end
  endtask

  task automatic test_reset_mid();
    int reqs = 0;
    int busys = 0;
    hold_reset();
    max_gd = 0; min_rd = 3; max_rd = 3;
    mem[0] = 3; mem[1] = 4; mem[2] = 6; mem[3] = 5; mem[4] = 5;
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (mem_req && mem_gnt && !mem_we && mem_addr == 16'd4) break;
    end
    @(negedge clock);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, pc, busy, halted, retired} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: req=%b we=%b addr=%0d wdata=%0d pc=%0d busy=%b retired=%0d, all must be 0",
               mem_req, mem_we, mem_addr, mem_wdata, pc, busy, retired);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mem_req) reqs++;
      if (busy) busys++;
    end
    n_checks++;
    if (reqs != 0 || busys != 0) begin
      n_fail++;
      $display("FAIL midrst_idle: req cycles %0d busy cycles %0d, both expected 0", reqs, busys);
    end
    n_checks++;
    if (n_writes != 0 || mem[4] !== 32'd5) begin
      n_fail++;
      $display("FAIL midrst_no_write: writes %0d mem4 %0d, expected 0 writes and mem4 5", n_writes, mem[4]);
    end
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_restart: req=%b addr=%0d expected req=1 addr=0", mem_req, mem_addr);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (retired == 32'd1) break;
    end
    n_checks++;
    if (mem[4] !== 32'd0 || pc !== 16'd6) begin
      n_fail++;
      $display("FAIL midrst_rerun: mem4 %0d pc %0d expected mem4 0 pc 6", mem[4], pc);
    end
  endtask

  task automatic test_random_wait();
    int          prog [0:35] = '{41,40,3, 40,41,9, 0,0,0, 42,43,12, 45,46,15, 43,43,21,
                                 0,0,0, 44,42,24, 46,44,27, 45,46,30, 42,45,33, 46,46,0};
    logic [31:0] refm [0:255];
    logic [31:0] a, b, c, r;
    logic [7:0]  pcm;
    bit          pw = 1'b0;
    logic [15:0] pa = '0;
    logic        pwe = 1'b0;
    logic [31:0] pwd = '0;
    int          bad = 0;
    hold_reset();
    max_gd = 3; min_rd = 0; max_rd = 3;
    for (int i = 0; i < 36; i++) mem[i] = prog[i];
    mem[40] = 32'd7; mem[41] = 32'd3; mem[42] = 32'hffff_fffe; mem[43] = 32'd0;
    mem[44] = 32'd100; mem[45] = 32'd1; mem[46] = 32'd5;
    for (int i = 0; i < 256; i++) refm[i] = mem[i];
    pcm = 8'd0;
    for (int k = 0; k < 10; k++) begin
      a = refm[pcm];
      b = refm[pcm + 8'd1];
      c = refm[pcm + 8'd2];
      r = refm[b[7:0]] - refm[a[7:0]];
      refm[b[7:0]] = r;
      if ($signed(r) <= 0) pcm = c[7:0];
      else pcm = pcm + 8'd3;
    end
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (pw) begin
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== pa || mem_we !== pwe || mem_wdata !== pwd) begin
          n_fail++;
          $display("FAIL req_stable: req=%b addr=%0d we=%b wdata=%0d, held values addr=%0d we=%b wdata=%0d",
                   mem_req, mem_addr, mem_we, mem_wdata, pa, pwe, pwd);
        end
      end
      pw  = mem_req && !mem_gnt;
      pa  = mem_addr;
      pwe = mem_we;
      pwd = mem_wdata;
      if (retired == 32'd10) break;
    end
    run = 1'b0;
    n_checks++;
    if (retired !== 32'd10) begin n_fail++; $display("FAIL rand_retired: got %0d expected 10", retired); end
    n_checks++;
    if (pc !== {8'd0, pcm}) begin n_fail++; $display("FAIL rand_pc: got %0d expected %0d", pc, pcm); end
    for (int i = 0; i < 64; i++) if (mem[i] !== refm[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rand_mem_image: %0d words differ, e.g. mem45=%0d expected %0d mem46=%0d expected %0d",
               bad, mem[45], refm[45], mem[46], refm[46]);
    end
  endtask

  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_width8();
    test_self_loop_halt();
    test_self_loop_no_halt();
    test_reset_mid();
    test_random_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
